// File: rtl/stage_accum_mc.sv
// stage_accum_mc: multi-channel fixed-point Viola-Jones stage accumulator.
// Each weak-classifier beat scales the node threshold by every channel's
// variance-normalisation factor. It then picks the left or right alpha per
// channel and adds it into that channel's accumulator. At stage end each
// accumulator is compared with the stage threshold to form the pass mask.
// Optional build macro STAGE_ACCUM_SAT_EN: saturate the product reduction and
// the accumulator add to the signed DATA_W range. When the macro is undefined,
// both operations wrap in two's complement.
module stage_accum_mc #(
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int CH     = 4,
    parameter int CNT_W  = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stage_start_i,
    input  logic [CNT_W-1:0]     num_weak_i,
    input  logic [DATA_W-1:0]    stage_thr_i,
    input  logic [CH*DATA_W-1:0] var_norm_i,
    input  logic                 weak_val_i,
    input  logic [DATA_W-1:0]    weak_thr_i,
    input  logic [DATA_W-1:0]    alpha_left_i,
    input  logic [DATA_W-1:0]    alpha_right_i,
    input  logic [CH*DATA_W-1:0] feat_sum_i,
    output logic                 ready_o,
    output logic                 stage_done_o,
    output logic [CH-1:0]        stage_pass_o,
    output logic [CH*DATA_W-1:0] stage_sum_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

`ifdef STAGE_ACCUM_SAT_EN
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      num_weak_q;
    logic [DATA_W-1:0]     stage_thr_q;
    logic [CH*DATA_W-1:0]  var_norm_q;
    logic                  ready_q;
    logic                  done_q;
    logic [CH-1:0]         pass_q;
    logic [CH*DATA_W-1:0]  sum_q;

    logic                  p1_vld_q;
    logic [CH*DATA_W-1:0]  prod_q;
    logic [CH*DATA_W-1:0]  feat_q;
    logic [DATA_W-1:0]     alpha_l_q;
    logic [DATA_W-1:0]     alpha_r_q;
    logic [CH*DATA_W-1:0]  acc_q;

    logic                  start_take;
    logic                  beat_take;
    logic [CH*DATA_W-1:0]  prod_d;
    logic [CH*DATA_W-1:0]  acc_d;
    logic [CH-1:0]         prod_unused;
    logic signed [2*DATA_W-1:0] mul_a;
    logic signed [2*DATA_W-1:0] mul_b;
    logic signed [2*DATA_W-1:0] mul_full;
    logic signed [2*DATA_W-1:0] mul_shr;
    logic [DATA_W-1:0]     sel;
`ifdef STAGE_ACCUM_SAT_EN
    logic [DATA_W:0]       add_ext;
`endif

    assign ready_o      = ready_q;
    assign stage_done_o = done_q;
    assign stage_pass_o = pass_q;
    assign stage_sum_o  = sum_q;

    // Accept starts in IDLE/ACCUM; a start in ACCUM discards a coincident beat.
    always_comb begin
        start_take = stage_start_i && ((state_q == IDLE) || (state_q == ACCUM));
        beat_take  = weak_val_i && (state_q == ACCUM) && !stage_start_i;
    end

    // P1 arithmetic: threshold * var_norm, shifted back to Q format per channel.
    always_comb begin
        prod_d      = '0;
        prod_unused = '0;
        mul_a       = '0;
        mul_b       = '0;
        mul_full    = '0;
        mul_shr     = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            mul_a    = {{DATA_W{weak_thr_i[DATA_W-1]}}, weak_thr_i};
            mul_b    = {{DATA_W{var_norm_q[k*DATA_W + DATA_W - 1]}},
                        var_norm_q[k*DATA_W +: DATA_W]};
            mul_full = mul_a * mul_b;
            mul_shr  = mul_full >>> FRAC;
`ifdef STAGE_ACCUM_SAT_EN
            // Fits only if every bit from DATA_W-1 upward is a sign copy.
            if ((&mul_shr[2*DATA_W-1:DATA_W-1]) || !(|mul_shr[2*DATA_W-1:DATA_W-1]))
                prod_d[k*DATA_W +: DATA_W] = mul_shr[DATA_W-1:0];
            else if (mul_shr[2*DATA_W-1])
                prod_d[k*DATA_W +: DATA_W] = SMIN;
            else
                prod_d[k*DATA_W +: DATA_W] = SMAX;
            prod_unused[k] = ^mul_full[FRAC-1:0];
`else
            prod_d[k*DATA_W +: DATA_W] = mul_shr[DATA_W-1:0];
            prod_unused[k] = ^{mul_full[FRAC-1:0], mul_shr[2*DATA_W-1:DATA_W]};
`endif
        end
    end

    // P2 arithmetic: signed compare selects the alpha, then accumulate.
    always_comb begin
        acc_d = acc_q;
        sel   = '0;
`ifdef STAGE_ACCUM_SAT_EN
        add_ext = '0;
`endif
        for (int unsigned k = 0; k < CH; k++) begin
            sel = ($signed(feat_q[k*DATA_W +: DATA_W]) >= $signed(prod_q[k*DATA_W +: DATA_W]))
                  ? alpha_r_q : alpha_l_q;
`ifdef STAGE_ACCUM_SAT_EN
            add_ext = {acc_q[k*DATA_W + DATA_W - 1], acc_q[k*DATA_W +: DATA_W]}
                    + {sel[DATA_W-1], sel};
            if (add_ext[DATA_W] != add_ext[DATA_W-1])
                acc_d[k*DATA_W +: DATA_W] = add_ext[DATA_W] ? SMIN : SMAX;
            else
                acc_d[k*DATA_W +: DATA_W] = add_ext[DATA_W-1:0];
`else
            acc_d[k*DATA_W +: DATA_W] = acc_q[k*DATA_W +: DATA_W] + sel;
`endif
        end
    end

    // Two-stage datapath: P1 registers products, P2 updates the accumulators.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p1_vld_q  <= 1'b0;
            prod_q    <= '0;
            feat_q    <= '0;
            alpha_l_q <= '0;
            alpha_r_q <= '0;
            acc_q     <= '0;
        end else if (start_take) begin
            p1_vld_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            p1_vld_q <= beat_take;
            if (beat_take) begin
                prod_q    <= prod_d;
                feat_q    <= feat_sum_i;
                alpha_l_q <= alpha_left_i;
                alpha_r_q <= alpha_right_i;
            end
            if (p1_vld_q)
                acc_q <= acc_d;
        end
    end

    // Stage control FSM with registered ready/done/pass/sum outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            num_weak_q  <= '0;
            stage_thr_q <= '0;
            var_norm_q  <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= '0;
            sum_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_take) begin
                num_weak_q  <= num_weak_i;
                stage_thr_q <= stage_thr_i;
                var_norm_q  <= var_norm_i;
                cnt_q       <= '0;
                if (num_weak_i == '0) begin
                    state_q <= DRAIN;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= ACCUM;
                    ready_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (beat_take) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == num_weak_q - CNT_W'(1)) begin
                                state_q <= DRAIN;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!p1_vld_q)
                            state_q <= DONE;
                    end
                    DONE: begin
                        for (int unsigned k = 0; k < CH; k++)
                            pass_q[k] <= $signed(acc_q[k*DATA_W +: DATA_W]) >= $signed(stage_thr_q);
                        sum_q   <= acc_q;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stage_accum_mc.sv
// Testbench for stage_accum_mc with two channels and Q16.16 data.
// Expected stage results are queued when a stage is launched and compared
// when stage_done_o fires. The bench follows STAGE_ACCUM_SAT_EN.
module tb_stage_accum_mc;

    localparam int DW  = 32;
    localparam int FR  = 16;
    localparam int NCH = 2;
    localparam int CW  = 10;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              stage_start_i;
    logic [CW-1:0]     num_weak_i;
    logic [DW-1:0]     stage_thr_i;
    logic [NCH*DW-1:0] var_norm_i;
    logic              weak_val_i;
    logic [DW-1:0]     weak_thr_i;
    logic [DW-1:0]     alpha_left_i;
    logic [DW-1:0]     alpha_right_i;
    logic [NCH*DW-1:0] feat_sum_i;
    logic              ready_o;
    logic              stage_done_o;
    logic [NCH-1:0]    stage_pass_o;
    logic [NCH*DW-1:0] stage_sum_o;

    always #5 clk = ~clk;

    stage_accum_mc #(
        .DATA_W (DW),
        .FRAC   (FR),
        .CH     (NCH),
        .CNT_W  (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stage_start_i (stage_start_i),
        .num_weak_i    (num_weak_i),
        .stage_thr_i   (stage_thr_i),
        .var_norm_i    (var_norm_i),
        .weak_val_i    (weak_val_i),
        .weak_thr_i    (weak_thr_i),
        .alpha_left_i  (alpha_left_i),
        .alpha_right_i (alpha_right_i),
        .feat_sum_i    (feat_sum_i),
        .ready_o       (ready_o),
        .stage_done_o  (stage_done_o),
        .stage_pass_o  (stage_pass_o),
        .stage_sum_o   (stage_sum_o)
    );

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [NCH*DW-1:0] sum;
        logic [NCH-1:0]    pass;
        int                lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [DW-1:0]  thr;
        logic [DW-1:0]  v0;
        logic [DW-1:0]  v1;
        logic [DW-1:0]  f0;
        logic [DW-1:0]  f1;
        logic [DW-1:0]  sthr;
        logic [DW-1:0]  s0;
        logic [DW-1:0]  s1;
        logic [NCH-1:0] pass;
    } vec_t;
    vec_t vt[6];

    always @(negedge clk) if (stage_done_o) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_stage(input logic [CW-1:0] nw, input logic [DW-1:0] sthr,
                               input logic [DW-1:0] v0, input logic [DW-1:0] v1);
        stage_start_i = 1'b1;
        num_weak_i    = nw;
        stage_thr_i   = sthr;
        var_norm_i    = {v1, v0};
        tick();
        stage_start_i = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] thr, input logic [DW-1:0] al, input logic [DW-1:0] ar,
                        input logic [DW-1:0] f0, input logic [DW-1:0] f1);
        weak_val_i    = 1'b1;
        weak_thr_i    = thr;
        alpha_left_i  = al;
        alpha_right_i = ar;
        feat_sum_i    = {f1, f0};
        tick();
        weak_val_i    = 1'b0;
    endtask

    task automatic expect_stage(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                input logic [NCH-1:0] pass, input int lat);
        exp_t e;
        e.sum  = {s1, s0};
        e.pass = pass;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        bit   got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (stage_done_o) got = 1'b1;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = sb.pop_front();
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL %s_done_timeout actual=none required=strobe", tag);
            end else begin
                check({tag, "_latency"}, 64'(n), 64'(e.lat));
                check({tag, "_sum"}, stage_sum_o, e.sum);
                check({tag, "_pass"}, 64'(stage_pass_o), 64'(e.pass));
            end
        end
    endtask

    initial begin
        int base;

        vt[0] = '{thr:32'h8000, v0:32'h20000, v1:32'h20000, f0:32'hFFFF, f1:32'h10000,
                  sthr:32'h1800, s0:32'h1000, s1:32'h2000, pass:2'b10};
        vt[1] = '{thr:32'hFFFF8000, v0:32'h10000, v1:32'h10000, f0:32'hFFFF8000, f1:32'hFFFF7FFF,
                  sthr:32'h2000, s0:32'h2000, s1:32'h1000, pass:2'b01};
        vt[2] = '{thr:32'h0, v0:32'h30000, v1:32'h30000, f0:32'h80000000, f1:32'h7FFFFFFF,
                  sthr:32'h1000, s0:32'h1000, s1:32'h2000, pass:2'b11};
        vt[3] = '{thr:32'h40000, v0:32'hFFFF0000, v1:32'h8000, f0:32'hFFFD0000, f1:32'h1FFFF,
                  sthr:32'h1001, s0:32'h2000, s1:32'h1000, pass:2'b01};
        vt[4] = '{thr:32'h3, v0:32'h18000, v1:32'hFFFE8000, f0:32'h3, f1:32'hFFFFFFFB,
                  sthr:32'h2000, s0:32'h1000, s1:32'h2000, pass:2'b10};
`ifdef STAGE_ACCUM_SAT_EN
        vt[5] = '{thr:32'h7FFFFFFF, v0:32'h20000, v1:32'h10000, f0:32'h0, f1:32'h7FFFFFFF,
                  sthr:32'h2000, s0:32'h1000, s1:32'h2000, pass:2'b10};
`else
        vt[5] = '{thr:32'h7FFFFFFF, v0:32'h20000, v1:32'h10000, f0:32'h0, f1:32'h7FFFFFFF,
                  sthr:32'h2000, s0:32'h2000, s1:32'h2000, pass:2'b11};
`endif

        rst_i = 1'b1;
        stage_start_i = 1'b0;
        num_weak_i = '0;
        stage_thr_i = '0;
        var_norm_i = '0;
        weak_val_i = 1'b0;
        weak_thr_i = '0;
        alpha_left_i = '0;
        alpha_right_i = '0;
        feat_sum_i = '0;
        tick();
        tick();
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_done", 64'(stage_done_o), 64'd0);
        check("reset_pass", 64'(stage_pass_o), 64'd0);
        check("reset_sum", stage_sum_o, 64'd0);
        rst_i = 1'b0;
        tick();

        // Two back-to-back beats, unit variance
        start_stage(10'd2, 32'h18000, 32'h10000, 32'h10000);
        expect_stage(32'h40000, 32'h10000, 2'b01, 3);
        beat(32'h8000, 32'hFFFF0000, 32'h20000, 32'h10000, 32'h4000);
        beat(32'h8000, 32'hFFFF0000, 32'h20000, 32'h10000, 32'h10000);
        wait_done("basic");
        check("basic_ready_after", 64'(ready_o), 64'd1);
        repeat (3) tick();
        check("basic_sum_held", stage_sum_o, {32'h10000, 32'h40000});

        // Single-beat vectors: scaling, signed compares, rounding, product overflow
        for (int i = 0; i < 6; i++) begin
            start_stage(10'd1, vt[i].sthr, vt[i].v0, vt[i].v1);
            expect_stage(vt[i].s0, vt[i].s1, vt[i].pass, 3);
            beat(vt[i].thr, 32'h1000, 32'h2000, vt[i].f0, vt[i].f1);
            wait_done($sformatf("vec%0d", i));
        end

        // Empty stages
        start_stage(10'd0, 32'h0, 32'h10000, 32'h10000);
        check("empty_ready_low", 64'(ready_o), 64'd0);
        expect_stage(32'h0, 32'h0, 2'b11, 2);
        wait_done("empty_thr0");
        start_stage(10'd0, 32'h1, 32'h10000, 32'h10000);
        expect_stage(32'h0, 32'h0, 2'b00, 2);
        wait_done("empty_thr1");
        start_stage(10'd0, 32'hFFFFFFFF, 32'h10000, 32'h10000);
        expect_stage(32'h0, 32'h0, 2'b11, 2);
        wait_done("empty_thrneg");

        // Abort mid-stage with a coincident beat
        tick();
        base = done_cnt;
        start_stage(10'd4, 32'h40, 32'h10000, 32'h10000);
        beat(32'h0, 32'h0, 32'h100000, 32'h0, 32'h0);
        beat(32'h0, 32'h0, 32'h100000, 32'h0, 32'h0);
        stage_start_i = 1'b1;
        num_weak_i    = 10'd4;
        stage_thr_i   = 32'h40;
        var_norm_i    = {32'h10000, 32'h10000};
        weak_val_i    = 1'b1;
        weak_thr_i    = 32'h0;
        alpha_right_i = 32'h100000;
        feat_sum_i    = '0;
        tick();
        stage_start_i = 1'b0;
        weak_val_i    = 1'b0;
        expect_stage(32'h40, 32'h40, 2'b11, 3);
        for (int i = 0; i < 4; i++)
            beat(32'h0, 32'h0, 32'h10, 32'h0, 32'h0);
        wait_done("abort");
        tick();
        check("abort_strobe_count", 64'(done_cnt - base), 64'd1);

        // Accumulator overflow in both directions
        start_stage(10'd2, 32'h0, 32'h10000, 32'h10000);
`ifdef STAGE_ACCUM_SAT_EN
        expect_stage(32'h7FFFFFFF, 32'h80000000, 2'b01, 3);
`else
        expect_stage(32'hFFFE0000, 32'h0, 2'b10, 3);
`endif
        beat(32'h0, 32'h80000000, 32'h7FFF0000, 32'h0, 32'hFFFFFFFF);
        beat(32'h0, 32'h80000000, 32'h7FFF0000, 32'h0, 32'hFFFFFFFF);
        wait_done("acc_ovf");

        // Reset while draining
        tick();
        start_stage(10'd1, 32'h0, 32'h10000, 32'h10000);
        beat(32'h0, 32'h0, 32'h5, 32'h0, 32'h0);
        check("drain_ready_low", 64'(ready_o), 64'd0);
        base = done_cnt;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_drain_ready", 64'(ready_o), 64'd1);
        check("rst_drain_done", 64'(stage_done_o), 64'd0);
        check("rst_drain_sum", stage_sum_o, 64'd0);
        check("rst_drain_pass", 64'(stage_pass_o), 64'd0);
        repeat (6) tick();
        check("rst_drain_no_strobe", 64'(done_cnt - base), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
